// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants and state encoding for the fetch stage
package inst_fetch_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_INST_W = 32;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction ROM bus between fetch stage and memory
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);

  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;

  modport master (
    output rom_ce,
    output rom_addr,
    input  rom_inst
  );

  modport slave (
    input  rom_ce,
    input  rom_addr,
    output rom_inst
  );

endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// rtl/inst_fetch_if_id_reg.sv - IF/ID pipeline register with flush, hold and bubble
module inst_fetch_if_id_reg
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int INST_W = DEFAULT_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [INST_W-1:0] fetch_inst,
  input  logic              fetch_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  // Flush clears, a stalled ID holds (also covers stall_id without stall_if),
  // a stalled IF alone inserts a bubble, otherwise capture the fetched word.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      id_pc    <= '0;
      id_inst  <= INST_W'(NOP_WORD);
      id_valid <= 1'b0;
    end else if (stall_id) begin
      id_pc    <= id_pc;
      id_inst  <= id_inst;
      id_valid <= id_valid;
    end else if (stall_if) begin
      id_pc    <= '0;
      id_inst  <= INST_W'(NOP_WORD);
      id_valid <= 1'b0;
    end else begin
      id_pc    <= fetch_pc;
      id_inst  <= fetch_inst;
      id_valid <= fetch_valid;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC owner, redirect FSM and ROM fetch initiator
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              ADDR_W   = DEFAULT_ADDR_W,
  parameter int              INST_W   = DEFAULT_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  inst_fetch_if.master      rom,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_target;
  logic              ce;
  logic              stall;

  // stall_id alone is an illegal controller vector; fold it into a PC hold.
  assign stall = stall_if | stall_id;

  assign rom.rom_ce   = ce;
  assign rom.rom_addr = pc;

  // Fetch FSM: PC sequencing, deferred branch redirect and exception flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_target <= '0;
      ce          <= CHIP_DISABLE;
    end else if (flush) begin
      state       <= RUN;
      pc          <= new_pc;
      pend_target <= '0;
      ce          <= CHIP_ENABLE;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          ce    <= CHIP_ENABLE;
        end
        RUN, PEND: begin
          ce <= CHIP_ENABLE;
          if (stall) begin
            // A branch seen while stalled is remembered; a newer one replaces it.
            if (branch_flag) begin
              state       <= PEND;
              pend_target <= branch_target;
            end
          end else if (state == PEND) begin
            state <= RUN;
            pc    <= pend_target;
          end else if (branch_flag) begin
            pc <= branch_target;
          end else begin
            pc <= pc + ADDR_W'(4);
          end
        end
        default: begin
          state <= IDLE;
          ce    <= CHIP_DISABLE;
        end
      endcase
    end
  end

  inst_fetch_if_id_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .fetch_pc    (pc),
    .fetch_inst  (rom.rom_inst),
    .fetch_valid (ce),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_valid    (id_valid)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_if = 1'b0;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int total = 0;
  int passed = 0;

  inst_fetch_if #(.ADDR_W(32), .INST_W(32)) rom_bus ();

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom           (rom_bus),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  // Combinational ROM: returns zero while disabled.
  always_comb begin
    rom_bus.rom_inst = rom_bus.rom_ce ? rom_word(rom_bus.rom_addr) : 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (rom_bus.rom_ce !== 1'b0) $display("FAIL reset_ce got %0b want 0", rom_bus.rom_ce); else passed++;
    total++; if (rom_bus.rom_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", rom_bus.rom_addr); else passed++;
    total++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) $display("FAIL reset_ifid got v=%0b pc=%h inst=%h want 0/0/0", id_valid, id_pc, id_inst); else passed++;
    rst = 1'b1;
    #1;
    total++; if (rom_bus.rom_ce !== 1'b0) $display("FAIL release_ce_low got %0b want 0", rom_bus.rom_ce); else passed++;
    tick();
    total++; if (rom_bus.rom_ce !== 1'b1 || rom_bus.rom_addr !== 32'h0) $display("FAIL first_fetch got ce=%0b addr=%h want 1/0", rom_bus.rom_ce, rom_bus.rom_addr); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL idle_slot_valid got %0b want 0", id_valid); else passed++;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h4) $display("FAIL seq_addr4 got %h want 4", rom_bus.rom_addr); else passed++;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== rom_word(32'h0)) $display("FAIL first_valid got v=%0b pc=%h inst=%h want 1/0/%h", id_valid, id_pc, id_inst, rom_word(32'h0)); else passed++;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h8 || id_pc !== 32'h4) $display("FAIL seq_addr8 got addr=%h id_pc=%h want 8/4", rom_bus.rom_addr, id_pc); else passed++;
  endtask

  task automatic test_stall();
    repeat (2) tick();
    total++; if (rom_bus.rom_addr !== 32'h10) $display("FAIL reach_10 got %h want 10", rom_bus.rom_addr); else passed++;
    stall_if = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (rom_bus.rom_addr !== 32'h10) $display("FAIL stall_hold_%0d got %h want 10", i, rom_bus.rom_addr); else passed++;
      total++; if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) $display("FAIL stall_bubble_%0d got v=%0b pc=%h inst=%h want 0/0/0", i, id_valid, id_pc, id_inst); else passed++;
    end
    stall_if = 1'b0;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h14 || id_pc !== 32'h10 || id_valid !== 1'b1) $display("FAIL stall_resume got addr=%h id_pc=%h v=%0b want 14/10/1", rom_bus.rom_addr, id_pc, id_valid); else passed++;
  endtask

  task automatic test_branch();
    flush = 1'b1; new_pc = 32'h0C;
    tick();
    flush = 1'b0;
    total++; if (rom_bus.rom_addr !== 32'h0C || id_valid !== 1'b0) $display("FAIL flush_to_0c got addr=%h v=%0b want 0c/0", rom_bus.rom_addr, id_valid); else passed++;
    branch_flag = 1'b1; branch_target = 32'h100;
    tick();
    branch_flag = 1'b0;
    total++; if (rom_bus.rom_addr !== 32'h100) $display("FAIL branch_target got %h want 100", rom_bus.rom_addr); else passed++;
    total++; if (id_pc !== 32'h0C || id_inst !== rom_word(32'h0C) || id_valid !== 1'b1) $display("FAIL delay_slot got pc=%h inst=%h v=%0b want 0c/%h/1", id_pc, id_inst, id_valid, rom_word(32'h0C)); else passed++;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h104 || id_pc !== 32'h100) $display("FAIL after_branch got addr=%h id_pc=%h want 104/100", rom_bus.rom_addr, id_pc); else passed++;
  endtask

  task automatic test_branch_stalled();
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rom_bus.rom_addr !== 32'h104) $display("FAIL pend_hold_%0d got %h want 104", i, rom_bus.rom_addr); else passed++;
    end
    stall_if = 1'b0; branch_flag = 1'b0;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h200) $display("FAIL pend_redirect got %h want 200", rom_bus.rom_addr); else passed++;
    total++; if (id_pc !== 32'h104 || id_valid !== 1'b1) $display("FAIL pend_slot got pc=%h v=%0b want 104/1", id_pc, id_valid); else passed++;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h204) $display("FAIL pend_after got %h want 204", rom_bus.rom_addr); else passed++;
  endtask

  task automatic test_flush_vs_branch();
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
    tick();
    flush = 1'b1; new_pc = 32'h180; branch_target = 32'h400;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h180) $display("FAIL flush_pc got %h want 180", rom_bus.rom_addr); else passed++;
    total++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) $display("FAIL flush_ifid got v=%0b pc=%h inst=%h want 0/0/0", id_valid, id_pc, id_inst); else passed++;
    flush = 1'b0; branch_flag = 1'b0; stall_if = 1'b0;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h184) $display("FAIL flush_drops_pend got %h want 184", rom_bus.rom_addr); else passed++;
    total++; if (id_pc !== 32'h180 || id_valid !== 1'b1) $display("FAIL flush_next_slot got pc=%h v=%0b want 180/1", id_pc, id_valid); else passed++;
  endtask

  task automatic test_wrap_and_reset();
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h0) $display("FAIL wrap_addr got %h want 0", rom_bus.rom_addr); else passed++;
    total++; if (id_pc !== 32'hFFFF_FFFC || id_inst !== rom_word(32'hFFFF_FFFC)) $display("FAIL wrap_slot got pc=%h inst=%h want fffffffc/%h", id_pc, id_inst, rom_word(32'hFFFF_FFFC)); else passed++;
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h500;
    tick();
    rst = 1'b0; stall_if = 1'b0; branch_flag = 1'b0;
    tick();
    total++; if (rom_bus.rom_ce !== 1'b0 || rom_bus.rom_addr !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0) $display("FAIL midreset got ce=%0b addr=%h v=%0b pc=%h want 0/0/0/0", rom_bus.rom_ce, rom_bus.rom_addr, id_valid, id_pc); else passed++;
    rst = 1'b1;
    tick();
    total++; if (rom_bus.rom_ce !== 1'b1 || rom_bus.rom_addr !== 32'h0) $display("FAIL rerelease got ce=%0b addr=%h want 1/0", rom_bus.rom_ce, rom_bus.rom_addr); else passed++;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h4) $display("FAIL no_stale_redirect got %h want 4", rom_bus.rom_addr); else passed++;
  endtask

  task automatic test_id_hold();
    stall_if = 1'b1; stall_id = 1'b1;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h4 || id_pc !== 32'h0 || id_inst !== rom_word(32'h0) || id_valid !== 1'b1) $display("FAIL both_stall_hold got addr=%h pc=%h inst=%h v=%0b want 4/0/%h/1", rom_bus.rom_addr, id_pc, id_inst, id_valid, rom_word(32'h0)); else passed++;
    stall_if = 1'b0;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h4 || id_pc !== 32'h0 || id_valid !== 1'b1) $display("FAIL id_only_stall got addr=%h pc=%h v=%0b want 4/0/1", rom_bus.rom_addr, id_pc, id_valid); else passed++;
    stall_id = 1'b0;
    tick();
    total++; if (rom_bus.rom_addr !== 32'h8 || id_pc !== 32'h4) $display("FAIL hold_release got addr=%h pc=%h want 8/4", rom_bus.rom_addr, id_pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_branch_stalled();
    test_flush_vs_branch();
    test_wrap_and_reset();
    test_id_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
